multicycle_controller: RTL
==========================

// Module: multicycle_controller
// PURPOSE
//  Multicycle successor to the single-cycle RV32I control unit. A Moore FSM (one Mealy term) sequences
//  fetch/decode/execute over several clocks through a shared memory port and ALU.
//  Adds a memory-ready handshake, an IO custom opcode and illegal-opcode trapping.
//  Sits beside the multicycle datapath; ALUControl is produced by the existing aludec.
// PARAMETERS
//  MEM_WAIT_EN  1  1: FETCH/MEMREAD/MEMWRITE stall until mem_ready; 0: mem_ready ignored, 1-cycle memory
//  IO_EN        1  1: opcode 7'b0001011 (custom-0) is a legal IO instruction; 0: it traps as illegal
//  BNE_EN       1  1: funct3[0] selects bne (taken = funct3[0]^Zero); 0: beq only (taken = Zero)
// PORTS
//  clk          in   1  rising-edge clock
//  reset_n      in   1  asynchronous active-low reset
//  op           in   7  opcode from instruction register
//  funct3       in   3  instr[14:12]
//  funct7b5     in   1  instr[30]
//  Zero         in   1  ALU zero flag
//  mem_ready    in   1  memory access completes this cycle
//  PCWrite      out  1  PC register load enable
//  AdrSrc       out  1  0: address=PC, 1: address=Result
//  MemWrite     out  1  data memory write strobe
//  IRWrite      out  1  instruction/OldPC register load
//  ResultSrc    out  2  00 ALUOut, 01 Data, 10 ALUResult
//  ALUSrcA      out  2  00 PC, 01 OldPC, 10 rs1
//  ALUSrcB      out  2  00 rs2, 01 Imm, 10 const 4
//  RegWrite     out  1  register file write enable
//  ImmSrc       out  2  00 I, 01 S, 10 B, 11 J; combinational decode of op, valid in every state
//  ALUControl   out  3  from aludec(op[5], funct3, funct7b5, ALUOp)
//  IO           out  1  IO strobe, exactly one cycle per IO instruction
//  nop          out  1  high in DECODE when op == 0 (bubble); FSM then returns to FETCH
//  illegal      out  1  sticky; high while in TRAP
// BEHAVIOUR
//  Reset: state=FETCH. While reset_n=0, every enable (PCWrite, MemWrite, IRWrite, RegWrite, IO) =0,
//   illegal=0. Reset mid-instruction aborts it; no partial write may occur after reset asserts.
//  Per-state asserts (all unlisted enables 0; ALUOp 00=add, 01=sub, 10=funct):
//   FETCH:   AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10;
//            IRWrite=PCWrite=rdy -> DECODE when rdy (rdy = mem_ready | ~MEM_WAIT_EN), else hold
//   DECODE:  ALUSrcA=01, ALUSrcB=01, ALUOp=00 (branch target). Next by op:
//            lw/sw->MEMADR; R->EXECR; I-ALU->EXECI; beq->BRANCH; jal->JAL;
//            custom-0 & IO_EN->IOOP; 0->FETCH (nop=1); else->TRAP
//   MEMADR:  ALUSrcA=10, ALUSrcB=01, ALUOp=00 -> lw: MEMREAD, sw: MEMWRITE
//   MEMREAD: ResultSrc=00, AdrSrc=1; -> MEMWB when rdy, else hold
//   MEMWRITE: ResultSrc=00, AdrSrc=1, MemWrite=1 held until rdy, then -> FETCH
//   MEMWB:   ResultSrc=01, RegWrite=1 -> FETCH
//   EXECR:   ALUSrcA=10, ALUSrcB=00, ALUOp=10 -> ALUWB
//   EXECI:   ALUSrcA=10, ALUSrcB=01, ALUOp=10 -> ALUWB
//   ALUWB:   ResultSrc=00, RegWrite=1 -> FETCH
//   BRANCH:  ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00;
//            PCWrite = taken (Mealy, combinational on Zero) -> FETCH
//   JAL:     ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCWrite=1 -> ALUWB (writes PC+4 to rd)
//   IOOP:    IO=1 -> FETCH
//   TRAP:    illegal=1, all enables 0; exits only via reset
//  Latency in cycles, zero wait: lw 5, sw 4, R/I 4, beq 3, jal 4, IO 3, nop 2.
//   Each stall cycle adds 1.
//  mem_ready is sampled only in FETCH/MEMREAD/MEMWRITE and is ignored elsewhere.
//  A mem_ready pulse in the same cycle as reset assertion has no effect.
// STRUCTURE
//  Package riscv_ctrl_pkg: state_t enum (13 states), opcode localparams (OP_LW, OP_SW, OP_R, OP_I,
//   OP_BEQ, OP_JAL, OP_IO), ALUOp and ResultSrc encodings.
//  Sub-module: existing aludec (ALUControl). Within this block: state register (always_ff),
//   next-state logic (always_comb), output decode (always_comb), ImmSrc decoder.
// TESTING
//  1 add x3,x1,x2 (op 0110011), mem_ready=1 -> FETCH,DECODE,EXECR,ALUWB; RegWrite=1 only in cycle 4
//  2 lw with mem_ready low 3 cycles in MEMREAD -> state held, RegWrite=0;
//    MEMWB exactly 1 cycle after mem_ready=1
//  3 beq with Zero=1 -> PCWrite=1 in BRANCH; bne (funct3=001) with Zero=1 -> PCWrite=0;
//    BNE_EN=0 bne, Zero=1 -> PCWrite=1
//  4 sw, reset_n pulsed low in MEMWRITE -> MemWrite drops immediately (async); state=FETCH after release
//  5 op=7'b1111111 -> TRAP, illegal=1 held 10 cycles, no enables; IO_EN=0 with op=0001011 -> TRAP
//  6 IO instr -> IO=1 for exactly 1 cycle; op=0 -> nop=1 in DECODE, then FETCH, no writes

Source files
------------

// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control unit: FSM states, opcodes,
// ALUOp and ResultSrc selections.
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWRITE,
    S_MEMWB,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_BRANCH,
    S_JAL,
    S_IOOP,
    S_TRAP
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_IO  = 7'b0001011;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

endpackage

// File: rtl/aludec.sv
// ALU operation decoder: maps ALUOp plus instruction fields onto the ALU control code.
module aludec
  import riscv_ctrl_pkg::*;
(
  input  logic       op5,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic [1:0] alu_op,
  output logic [2:0] alu_control
);

  always_comb begin
    alu_control = 3'b000;
    case (alu_op)
      ALUOP_ADD: alu_control = 3'b000;
      ALUOP_SUB: alu_control = 3'b001;
      ALUOP_FUNCT: begin
        case (funct3)
          3'b000:  alu_control = (op5 & funct7b5) ? 3'b001 : 3'b000;
          3'b010:  alu_control = 3'b101;
          3'b110:  alu_control = 3'b011;
          3'b111:  alu_control = 3'b010;
          default: alu_control = 3'b000;
        endcase
      end
      default: alu_control = 3'b000;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RV32I control FSM: sequences fetch/decode/execute through a shared
// memory port and ALU, with memory-ready stalls, an IO opcode and illegal trapping.
//
// state    | meaning
// FETCH    | read instruction at PC, PC <= PC+4 when memory ready
// DECODE   | compute branch target, dispatch on opcode
// MEMADR   | rs1 + imm for load/store
// MEMREAD  | load data read, waits for memory ready
// MEMWRITE | store strobe, held until memory ready
// MEMWB    | load data written to rd
// EXECR    | register-register ALU op
// EXECI    | register-immediate ALU op
// ALUWB    | ALU result written to rd
// BRANCH   | compare, PC <= target when taken
// JAL      | PC <= target, PC+4 computed for rd
// IOOP     | single-cycle IO strobe
// TRAP     | illegal opcode, parked until reset
module multicycle_controller
  import riscv_ctrl_pkg::*;
#(
  parameter bit MEM_WAIT_EN = 1'b1,
  parameter bit IO_EN       = 1'b1,
  parameter bit BNE_EN      = 1'b1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       RegWrite,
  output logic [1:0] ImmSrc,
  output logic [2:0] ALUControl,
  output logic       IO,
  output logic       nop,
  output logic       illegal
);

  state_t     state, state_nxt;
  logic       rdy, taken;
  logic [1:0] alu_op;
  logic       pc_w, mem_w, ir_w, reg_w, io_s;

  assign rdy   = mem_ready | ~MEM_WAIT_EN;
  assign taken = BNE_EN ? (funct3[0] ^ Zero) : Zero;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_FETCH;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_FETCH:    if (rdy) state_nxt = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_nxt = S_MEMADR;
          OP_R:         state_nxt = S_EXECR;
          OP_I:         state_nxt = S_EXECI;
          OP_BEQ:       state_nxt = S_BRANCH;
          OP_JAL:       state_nxt = S_JAL;
          OP_IO:        state_nxt = IO_EN ? S_IOOP : S_TRAP;
          7'd0:         state_nxt = S_FETCH;
          default:      state_nxt = S_TRAP;
        endcase
      end
      S_MEMADR:   state_nxt = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  if (rdy) state_nxt = S_MEMWB;
      S_MEMWRITE: if (rdy) state_nxt = S_FETCH;
      S_MEMWB:    state_nxt = S_FETCH;
      S_EXECR:    state_nxt = S_ALUWB;
      S_EXECI:    state_nxt = S_ALUWB;
      S_ALUWB:    state_nxt = S_FETCH;
      S_BRANCH:   state_nxt = S_FETCH;
      S_JAL:      state_nxt = S_ALUWB;
      S_IOOP:     state_nxt = S_FETCH;
      S_TRAP:     state_nxt = S_TRAP;
      default:    state_nxt = S_FETCH;
    endcase
  end

  always_comb begin
    pc_w      = 1'b0;
    mem_w     = 1'b0;
    ir_w      = 1'b0;
    reg_w     = 1'b0;
    io_s      = 1'b0;
    AdrSrc    = 1'b0;
    ResultSrc = RES_ALUOUT;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    alu_op    = ALUOP_ADD;
    case (state)
      S_FETCH: begin
        ALUSrcB   = 2'b10;
        ResultSrc = RES_ALURESULT;
        ir_w      = rdy;
        pc_w      = rdy;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      S_MEMREAD:  AdrSrc = 1'b1;
      S_MEMWRITE: begin
        AdrSrc = 1'b1;
        mem_w  = 1'b1;
      end
      S_MEMWB: begin
        ResultSrc = RES_DATA;
        reg_w     = 1'b1;
      end
      S_EXECR: begin
        ALUSrcA = 2'b10;
        alu_op  = ALUOP_FUNCT;
      end
      S_EXECI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        alu_op  = ALUOP_FUNCT;
      end
      S_ALUWB:  reg_w = 1'b1;
      S_BRANCH: begin
        ALUSrcA = 2'b10;
        alu_op  = ALUOP_SUB;
        pc_w    = taken;
      end
      S_JAL: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        pc_w    = 1'b1;
      end
      S_IOOP:  io_s = 1'b1;
      default: ;
    endcase
  end

  // Enables are gated by reset_n so nothing can write while reset is held low.
  assign PCWrite  = pc_w  & reset_n;
  assign MemWrite = mem_w & reset_n;
  assign IRWrite  = ir_w  & reset_n;
  assign RegWrite = reg_w & reset_n;
  assign IO       = io_s  & reset_n;
  assign nop      = (state == S_DECODE) && (op == 7'd0);
  assign illegal  = (state == S_TRAP);

  always_comb begin
    case (op)
      OP_SW:   ImmSrc = 2'b01;
      OP_BEQ:  ImmSrc = 2'b10;
      OP_JAL:  ImmSrc = 2'b11;
      default: ImmSrc = 2'b00;
    endcase
  end

  aludec u_aludec (
    .op5        (op[5]),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .alu_op     (alu_op),
    .alu_control(ALUControl)
  );

endmodule
